// File: rtl/photo_cnt_window_sched.sv
// Gate-window scheduler for the photo-interrupter counter channels.
// Times back-to-back windows. At each window end it strobes latch+clear to the enabled
// channels, captures their counts in a shadow file, and drains them one channel per
// snap_valid/snap_ready handshake. A one-cycle irq marks the end of each drain.
module photo_cnt_window_sched #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cfg_enable,
  input  logic [WIN_W-1:0]        cfg_win_len,
  input  logic [N_CH-1:0]         cfg_ch_mask,
  input  logic [N_CH*CNT_W-1:0]   cnt_value,
  output logic [N_CH-1:0]         cnt_latch_clr,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [3:0]              snap_ch,
  output logic [CNT_W-1:0]        snap_data,
  output logic                    irq,
  output logic [7:0]              win_seq,
  output logic                    overrun,
  input  logic                    ovr_clr
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [WIN_W-1:0]   timer;
  logic [WIN_W-1:0]   len_m1;     // effective window length minus one
  logic [N_CH-1:0]    win_mask;   // mask of the window currently being timed
  logic [N_CH-1:0]    pend;       // channels still waiting to be drained
  logic               stop_req;   // enable dropped while draining
  logic [CNT_W-1:0]   shadow [N_CH];

  logic [WIN_W-1:0]   cfg_len_m1;
  logic               expire;
  logic               fire;
  logic [N_CH-1:0]    pend_rem;
  logic               drain_done;
  logic               stopping;
  logic               going_run;
  logic               strobe_next;
  logic [3:0]         first_win;
  logic [3:0]         first_rem;

  // Lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [3:0] first_ch(input logic [N_CH-1:0] m);
    first_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (m[k]) first_ch = 4'(k);
    end
  endfunction

  // Effective window length: lengths 0 and 1 behave as 2, so the value is never below 1.
  always_comb begin
    // NOTE: assign a default before any condition so always_comb never infers a latch.
    cfg_len_m1 = cfg_win_len - WIN_W'(1);
    if (cfg_win_len < WIN_W'(2)) cfg_len_m1 = WIN_W'(1);
  end

  assign expire     = (state != IDLE) && (timer == len_m1);
  assign fire       = snap_valid && snap_ready;
  assign pend_rem   = pend & ~(N_CH'(1) << snap_ch);
  assign drain_done = (state == DRAIN) && fire && (pend_rem == '0);
  assign stopping   = stop_req || !cfg_enable;
  assign first_win  = first_ch(win_mask);
  assign first_rem  = first_ch(pend_rem);

  // The strobe is a registered output, so it is decided one cycle early: the next cycle is
  // the expiry when the timer is about to reach len_m1 and that cycle will be spent in RUN.
  // An expiry cycle itself never precedes another expiry because the length is at least 2.
  assign going_run   = ((state == RUN) && cfg_enable) || (drain_done && !stopping);
  assign strobe_next = going_run && ((timer + WIN_W'(1)) == len_m1);

  // Window timer, drain sequencer and all registered outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state         <= IDLE;
      timer         <= '0;
      len_m1        <= '0;
      win_mask      <= '0;
      pend          <= '0;
      stop_req      <= 1'b0;
      cnt_latch_clr <= '0;
      snap_valid    <= 1'b0;
      snap_ch       <= '0;
      snap_data     <= '0;
      irq           <= 1'b0;
      win_seq       <= '0;
      overrun       <= 1'b0;
      // NOTE: the shadow file is small and must read as zero after reset, so it is reset
      // explicitly; a large RAM-style array would normally be left unreset.
      for (int k = 0; k < N_CH; k++) shadow[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read in this block
      // sees the value from before the clock edge.
      irq           <= 1'b0;
      cnt_latch_clr <= strobe_next ? win_mask : '0;

      // Clear first so that a set in the same cycle (in DRAIN below) wins.
      if (ovr_clr) overrun <= 1'b0;

      // Windows run back-to-back in RUN and DRAIN; config is resampled at every expiry.
      if (expire) begin
        timer    <= '0;
        win_seq  <= win_seq + 8'd1;
        win_mask <= cfg_ch_mask;
        len_m1   <= cfg_len_m1;
      end else if (state != IDLE) begin
        timer <= timer + WIN_W'(1);
      end else begin
        timer <= '0;
      end

      case (state)
        IDLE: begin
          if (cfg_enable) begin
            state    <= RUN;
            win_mask <= cfg_ch_mask;
            len_m1   <= cfg_len_m1;
          end
        end

        RUN: begin
          if (expire) begin
            if (win_mask != '0) begin
              state      <= DRAIN;
              pend       <= win_mask;
              stop_req   <= !cfg_enable;
              for (int k = 0; k < N_CH; k++) begin
                if (win_mask[k]) shadow[k] <= cnt_value[k*CNT_W +: CNT_W];
              end
              snap_valid <= 1'b1;
              snap_ch    <= first_win;
              snap_data  <= cnt_value[int'(first_win)*CNT_W +: CNT_W];
            end else begin
              irq <= 1'b1;
              if (!cfg_enable) state <= IDLE;
            end
          end else if (!cfg_enable) begin
            state <= IDLE;
          end
        end

        DRAIN: begin
          // The live counters were not cleared for this window, so its counts are lost.
          if (expire) overrun <= 1'b1;
          if (!cfg_enable) stop_req <= 1'b1;
          if (fire) begin
            pend <= pend_rem;
            if (pend_rem == '0) begin
              snap_valid <= 1'b0;
              irq        <= 1'b1;
              state      <= stopping ? IDLE : RUN;
            end else begin
              snap_ch   <= first_rem;
              snap_data <= shadow[first_rem[IW-1:0]];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
